mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage downstream of execute. Consumes the execute result XOut as the data
//  address or pass-through value, and read2Data as the store data. Runs loads and
//  stores against a multi-cycle data memory using a req/done handshake, and stalls
//  upstream while an access is in flight. Presents a registered MEM/WB result.
//  Also detects halt, misaligned accesses, illegal read+write and memory timeout.
// PARAMETERS
//  DATA_W    16   datapath width
//  TIMEOUT   255  max cycles waiting for mem_done in BUSY before err is raised (>=1)
// PORTS
//  clk        in   1       clock
//  rst        in   1       asynchronous active-high reset
//  valid_in   in   1       instruction valid from execute; inputs stable while stall=1
//  XOut       in   DATA_W  execute result: address for mem ops, else result
//  wrData     in   DATA_W  store data (read2Data forwarded from execute)
//  MemRead    in   1       load
//  MemWrite   in   1       store
//  Halt       in   1       HALT instruction
//  mem_req    out  1       memory request, held high through BUSY
//  mem_wr     out  1       1=write, 0=read; valid while mem_req
//  mem_addr   out  DATA_W  latched address
//  mem_wdata  out  DATA_W  latched store data
//  mem_rdata  in   DATA_W  read data, valid when mem_done
//  mem_done   in   1       access complete (single-cycle pulse)
//  stall      out  1       hold execute/upstream stages
//  out_valid  out  1       registered: result valid to writeback
//  result     out  DATA_W  registered: load data or pass-through XOut
//  halted     out  1       sticky halt indicator
//  err        out  1       registered one-cycle error pulse, coincident with out_valid
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_req, mem_wr, out_valid, halted, err = 0;
//   result, mem_addr, mem_wdata = 0; watchdog counter = 0.
//  States: IDLE, BUSY, HALTED (2-bit encoding).
//  start = IDLE & valid_in & (MemRead|MemWrite) & !Halt & legal, where
//   legal = !XOut[0] & !(MemRead&MemWrite).
//  stall = start | (BUSY & !mem_done), combinational.
//  IDLE, valid_in, no mem op, no Halt: next edge result<=XOut, out_valid<=1 (1-cycle latency).
//  IDLE, start: latch mem_addr<=XOut, mem_wdata<=wrData, mem_wr<=MemWrite; go to BUSY.
//  IDLE, valid_in, mem op but !legal: no request issued; next edge out_valid<=1,
//   err<=1, result<=XOut; stay in IDLE.
//  BUSY: mem_req=1. On mem_done: result<=mem_rdata for a read, result<=mem_addr
//   for a write; out_valid<=1; state<=IDLE; mem_req drops on the same edge.
//   Minimum load/store latency: out_valid is asserted 2 cycles after the start cycle.
//  Watchdog: counts BUSY cycles and clears on BUSY entry. When the count reaches
//   TIMEOUT without mem_done: err<=1, out_valid<=1, result<=0, state<=IDLE.
//  Halt has priority over MemRead/MemWrite: IDLE & valid_in & Halt -> HALTED.
//   halted<=1, one out_valid pulse with result<=XOut.
//  HALTED: absorbing until reset. stall=0, out_valid=0, all inputs ignored.
//  out_valid and err are one-cycle pulses; they are 0 on any cycle without a completion.
//  Boundary cases:
//   - mem_done in IDLE or HALTED is ignored.
//   - valid_in=0 in IDLE: outputs hold, except out_valid/err, which go to 0.
//   - mem_done on the same cycle the watchdog expires: mem_done wins, no err.
//   - Reset mid-BUSY: mem_req drops immediately (async); no out_valid is produced.
// STRUCTURE
//  Shared package: state encodings (MS_IDLE=2'b00, MS_BUSY=2'b01, MS_HALTED=2'b10),
//   default TIMEOUT constant.
//  One natural sub-module: mem_watchdog (counter, clear/enable in, expired out),
//   width $clog2(TIMEOUT+1).
//  Remainder: one state register block and one combinational next-state/output block.
// TESTING
//  1 ALU pass: valid_in, XOut=16'h1234, no mem op -> next cycle out_valid=1,
//    result=16'h1234, stall never 1.
//  2 Load: XOut=16'h0040, MemRead; memory asserts mem_done 3 cycles after req with
//    rdata=16'hBEEF -> stall high 4 cycles, mem_addr=16'h0040, mem_wr=0,
//    result=16'hBEEF the cycle after done.
//  3 Store then load back-to-back: write 16'h00A5 to 16'h0010, then read 16'h0010
//    -> two separate req/done handshakes, second result=16'h00A5, no err.
//  4 Misaligned: MemWrite with XOut=16'h0011 -> mem_req never rises, err=1 and
//    out_valid=1 for one cycle. MemRead&MemWrite together -> same response.
//  5 Timeout: TIMEOUT=4, mem_done withheld -> err pulse after 4 BUSY cycles,
//    state returns to IDLE; a late mem_done is ignored.
//  6 Halt and reset: Halt with MemRead=1 -> no request, halted=1 sticky, later
//    valid_in ignored. Assert rst mid-BUSY -> mem_req=0 immediately, halted=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: state encodings and default sizing.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      MS_IDLE   = 2'b00,
      MS_BUSY   = 2'b01,
      MS_HALTED = 2'b10
   } ms_state_e;

   localparam int unsigned MS_DATA_W  = 16;
   localparam int unsigned MS_TIMEOUT = 255;

endpackage

// File: rtl/mem_stage_watchdog.sv
// Watchdog for outstanding memory accesses: counts cycles spent waiting and
// flags expiry on the last allowed cycle so the stage can abort on that edge.
module mem_watchdog
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = MS_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt;

   // Wait-cycle counter: cleared when an access is launched, advances while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + ONE;
      end
   end

   // The TIMEOUT-th waiting cycle is the last one; the abort happens at its end.
   assign expired = en & (cnt == LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory stage: runs loads/stores against a multi-cycle memory with a req/done
// handshake, stalls upstream while an access is outstanding, and presents a
// registered result to writeback. Also handles halt, misaligned/illegal ops
// and memory timeout.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  MS_IDLE   | accepting instructions; pass-through and error results
//  MS_BUSY   | memory request outstanding, waiting for mem_done/timeout
//  MS_HALTED | HALT retired; absorbing until reset
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = MS_DATA_W,
   parameter int unsigned TIMEOUT = MS_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] XOut,
   input  logic [DATA_W-1:0] wrData,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              Halt,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   output logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] result,
   output logic              halted,
   output logic              err
);

   ms_state_e         state, nxt_state;
   logic              mem_op, legal, start, busy, expired;
   logic              nxt_out_valid, nxt_err, nxt_halted, nxt_wr;
   logic [DATA_W-1:0] nxt_result, nxt_addr, nxt_wdata;

   assign mem_op  = MemRead | MemWrite;
   assign legal   = ~XOut[0] & ~(MemRead & MemWrite);
   assign start   = (state == MS_IDLE) & valid_in & mem_op & ~Halt & legal;
   assign busy    = (state == MS_BUSY);
   assign stall   = start | (busy & ~mem_done);
   // Request follows the registered state so an async reset drops it at once.
   assign mem_req = busy;

   mem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (start),
      .en      (busy),
      .expired (expired)
   );

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= MS_IDLE;
         out_valid <= 1'b0;
         err       <= 1'b0;
         halted    <= 1'b0;
         result    <= '0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= nxt_state;
         out_valid <= nxt_out_valid;
         err       <= nxt_err;
         halted    <= nxt_halted;
         result    <= nxt_result;
         mem_wr    <= nxt_wr;
         mem_addr  <= nxt_addr;
         mem_wdata <= nxt_wdata;
      end
   end

   // Next-state logic; halt takes priority over any memory operation.
   always_comb begin
      nxt_state = state;
      case (state)
         MS_IDLE: begin
            if (valid_in & Halt) begin
               nxt_state = MS_HALTED;
            end else if (start) begin
               nxt_state = MS_BUSY;
            end
         end
         MS_BUSY: begin
            if (mem_done | expired) begin
               nxt_state = MS_IDLE;
            end
         end
         MS_HALTED: nxt_state = MS_HALTED;
         default:   nxt_state = MS_IDLE;
      endcase
   end

   // Next values of registered outputs; out_valid/err default low so they pulse.
   always_comb begin
      nxt_out_valid = 1'b0;
      nxt_err       = 1'b0;
      nxt_halted    = halted;
      nxt_result    = result;
      nxt_wr        = mem_wr;
      nxt_addr      = mem_addr;
      nxt_wdata     = mem_wdata;
      case (state)
         MS_IDLE: begin
            if (valid_in) begin
               if (Halt) begin
                  nxt_halted    = 1'b1;
                  nxt_out_valid = 1'b1;
                  nxt_result    = XOut;
               end else if (mem_op) begin
                  if (legal) begin
                     nxt_addr  = XOut;
                     nxt_wdata = wrData;
                     nxt_wr    = MemWrite;
                  end else begin
                     nxt_out_valid = 1'b1;
                     nxt_err       = 1'b1;
                     nxt_result    = XOut;
                  end
               end else begin
                  nxt_out_valid = 1'b1;
                  nxt_result    = XOut;
               end
            end
         end
         MS_BUSY: begin
            // mem_done wins over a simultaneous watchdog expiry.
            if (mem_done) begin
               nxt_out_valid = 1'b1;
               nxt_result    = mem_wr ? mem_addr : mem_rdata;
            end else if (expired) begin
               nxt_out_valid = 1'b1;
               nxt_err       = 1'b1;
               nxt_result    = '0;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized instruction mix,
// a scoreboard of expected writeback results and a behavioural memory device.
module tb_mem_stage;

   localparam int DW = 16;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in, MemRead, MemWrite, Halt, mem_done;
   logic [DW-1:0] XOut, wrData, mem_rdata;
   logic          mem_req, mem_wr, stall, out_valid, halted, err;
   logic [DW-1:0] mem_addr, mem_wdata, result;

   mem_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .XOut      (XOut),
      .wrData    (wrData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Halt      (Halt),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done),
      .stall     (stall),
      .out_valid (out_valid),
      .result    (result),
      .halted    (halted),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] res;
      logic          err;
   } exp_t;

   typedef struct {
      logic [DW-1:0] addr;
      logic          wr;
      logic [DW-1:0] wdata;
      int            d;
   } req_t;

   exp_t          exp_q[$];
   req_t          req_q[$];
   logic [DW-1:0] ref_mem [logic [DW-1:0]];
   logic [DW-1:0] dev_mem [logic [DW-1:0]];
   bit            model_halted = 0;
   int            total = 0;
   int            bad   = 0;

   function automatic logic [DW-1:0] init_val(input logic [DW-1:0] a);
      return a ^ 16'h5A5A;
   endfunction

   function logic [DW-1:0] ref_rd(input logic [DW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function logic [DW-1:0] dev_rd(input logic [DW-1:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic push_exp(input logic [DW-1:0] r, input logic e);
      exp_t x;
      x.res = r;
      x.err = e;
      exp_q.push_back(x);
   endtask

   task automatic push_req(input logic [DW-1:0] a, input logic w, input logic [DW-1:0] wd, input int d);
      req_t r;
      r.addr  = a;
      r.wr    = w;
      r.wdata = wd;
      r.d     = d;
      req_q.push_back(r);
   endtask

   // Monitor: every writeback pulse must match the oldest expected result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL spurious_out_valid: got result %h err %b, none expected", result, err);
               end else begin
                  e = exp_q.pop_front();
                  check("result", {16'h0, result}, {16'h0, e.res});
                  check("err", {31'h0, err}, {31'h0, e.err});
               end
            end else begin
               check("err_without_valid", {31'h0, err}, 32'h0);
            end
         end
      end
   end

   // Memory device: answers each request after its scheduled delay, or stays
   // silent past the timeout and then sends a late, ignored done.
   initial begin
      req_t r;
      int   g;
      mem_done  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req && !rst) begin
            if (req_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_mem_req: addr %h wr %b, no request expected", mem_addr, mem_wr);
               g = 0;
               while (mem_req && g < 100) begin
                  @(negedge clk);
                  g++;
               end
            end else begin
               r = req_q.pop_front();
               check("mem_addr", {16'h0, mem_addr}, {16'h0, r.addr});
               check("mem_wr", {31'h0, mem_wr}, {31'h0, r.wr});
               if (r.wr) check("mem_wdata", {16'h0, mem_wdata}, {16'h0, r.wdata});
               if (r.d < TO) begin
                  repeat (r.d) @(negedge clk);
                  if (mem_wr) dev_mem[mem_addr] = mem_wdata;
                  mem_rdata = dev_rd(mem_addr);
                  mem_done  = 1'b1;
                  @(negedge clk);
                  mem_done  = 1'b0;
                  mem_rdata = DW'($urandom);
                  check("mem_req_drop", {31'h0, mem_req}, 32'h0);
               end else begin
                  g = 0;
                  while (mem_req && g < 100) begin
                     @(negedge clk);
                     g++;
                  end
                  mem_rdata = DW'($urandom);
                  mem_done  = 1'b1;
                  @(negedge clk);
                  mem_done  = 1'b0;
               end
            end
         end
      end
   end

   // Issue one instruction, predict its outcome from the instruction semantics,
   // and check stall duration and writeback latency.
   task automatic issue(input logic rd, input logic wr, input logic hlt,
                        input logic [DW-1:0] x, input logic [DW-1:0] wd, input int d);
      int exp_stall, scnt, guard;
      bit wait_edge, exp_ov;
      exp_stall = 0;
      wait_edge = 0;
      exp_ov    = !model_halted;
      if (model_halted) begin
         exp_stall = 0;
      end else if (hlt) begin
         push_exp(x, 1'b0);
         model_halted = 1;
      end else if (!(rd || wr)) begin
         push_exp(x, 1'b0);
      end else if (x[0] || (rd && wr)) begin
         push_exp(x, 1'b1);
      end else begin
         push_req(x, wr, wd, d);
         if (d < TO) begin
            exp_stall = 1 + d;
            wait_edge = 1;
            if (wr) begin
               push_exp(x, 1'b0);
               ref_mem[x] = wd;
            end else begin
               push_exp(ref_rd(x), 1'b0);
            end
         end else begin
            exp_stall = 1 + TO;
            push_exp('0, 1'b1);
         end
      end
      @(negedge clk);
      valid_in = 1'b1;
      MemRead  = rd;
      MemWrite = wr;
      Halt     = hlt;
      XOut     = x;
      wrData   = wd;
      #1;
      scnt = stall ? 1 : 0;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Halt     = 1'b0;
      XOut     = DW'($urandom);
      wrData   = DW'($urandom);
      @(negedge clk);
      #1;
      guard = 0;
      while (stall && guard < 50) begin
         scnt++;
         guard++;
         @(negedge clk);
         #1;
      end
      check("stall_cycles", scnt, exp_stall);
      if (wait_edge) begin
         @(posedge clk);
         #1;
      end
      check("out_valid_latency", {31'h0, out_valid}, {31'h0, exp_ov});
   endtask

   initial begin
      int k;
      logic [DW-1:0] a;
      rst      = 1'b1;
      valid_in = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Halt     = 1'b0;
      XOut     = '0;
      wrData   = '0;
      #1;
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_result", {16'h0, result}, 32'h0);
      check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
      check("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      ref_mem[16'h0040] = 16'hBEEF;
      dev_mem[16'h0040] = 16'hBEEF;

      issue(0, 0, 0, 16'h1234, 16'h0000, 0);      // ALU pass-through
      issue(1, 0, 0, 16'h0040, 16'h0000, 3);      // load, done 3 cycles after req
      issue(0, 1, 0, 16'h0010, 16'h00A5, 0);      // store, fastest done
      issue(1, 0, 0, 16'h0010, 16'h0000, 1);      // load back stored value
      issue(0, 1, 0, 16'h0011, 16'h7777, 0);      // misaligned store
      issue(1, 1, 0, 16'h0020, 16'h1111, 0);      // read and write together
      issue(1, 0, 0, 16'h0022, 16'h0000, TO);     // timeout, late done
      issue(0, 1, 0, 16'h0024, 16'h3333, TO + 2); // store timeout, no write
      issue(1, 0, 0, 16'h0024, 16'h0000, 0);      // location untouched by aborted store

      for (int i = 0; i < 150; i++) begin
         k = int'($urandom_range(0, 9));
         a = {10'h0, 5'($urandom_range(0, 31)), 1'b0};
         case (k)
            0, 1, 2: issue(0, 0, 0, DW'($urandom), DW'($urandom), 0);
            3, 4:    issue(1, 0, 0, a, DW'($urandom), int'($urandom_range(0, TO - 1)));
            5, 6:    issue(0, 1, 0, a, DW'($urandom), int'($urandom_range(0, TO - 1)));
            7:       issue($urandom_range(0, 1) == 1, 1, 0, a | 16'h0001, DW'($urandom), 0);
            8:       issue(1, 1, 0, a, DW'($urandom), 0);
            default: issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 ? 1'b0 : 1'b1,
                           0, a, DW'($urandom), int'($urandom_range(TO, TO + 2)));
         endcase
      end

      issue(1, 0, 1, 16'h0030, 16'h0000, 0);      // halt beats the load
      check("halted_set", {31'h0, halted}, 32'h1);
      issue(0, 0, 0, 16'h5555, 16'h0000, 0);
      issue(1, 0, 0, 16'h0030, 16'h0000, 0);
      issue(0, 1, 0, 16'h0032, 16'h0001, 0);
      check("halted_sticky", {31'h0, halted}, 32'h1);

      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("halted_cleared", {31'h0, halted}, 32'h0);
      model_halted = 0;
      @(negedge clk);
      rst = 1'b0;

      // Reset while an access is outstanding.
      push_req(16'h0020, 1'b0, 16'h0000, TO + 10);
      @(negedge clk);
      valid_in = 1'b1;
      MemRead  = 1'b1;
      XOut     = 16'h0020;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      MemRead  = 1'b0;
      @(negedge clk);
      #1;
      check("busy_mem_req", {31'h0, mem_req}, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_busy_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_busy_halted", {31'h0, halted}, 32'h0);
      check("rst_busy_out_valid", {31'h0, out_valid}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      issue(0, 0, 0, 16'hCAFE, 16'h0000, 0);
      repeat (4) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 32'h0);
      check("req_q_drained", req_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "global timeout");
   end

endmodule
